// File: rtl/f2i_share_arbiter_pkg.sv
// Shared types and constants for the shared float-to-int conversion arbiter.
// Holds the sequencer state encoding and the IEEE-754 / int32 limits.
package f2i_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } f2i_state_e;

  localparam int          F32_BIAS     = 127;
  localparam logic [31:0] INT_MAX      = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN      = 32'h8000_0000;
  // -2^31 is the only operand with E==31 that is representable exactly
  localparam logic [31:0] F32_NEG_2P31 = 32'hCF00_0000;

  function automatic logic [31:0] sat_value(input logic sign);
    return sign ? INT_MIN : INT_MAX;
  endfunction

endpackage

// File: rtl/f2i_share_arbiter_convert_core.sv
// Combinational float32 -> int32 converter, truncating toward zero and
// saturating out-of-range, infinite and NaN inputs.
module f2i_convert_core
  import f2i_pkg::*;
(
  input  logic [31:0] op,
  output logic [31:0] res,
  output logic        sat
);

  logic              sign;
  logic [7:0]        exp_b;
  logic [22:0]       frac;
  logic signed [9:0] exp_unb;
  logic [31:0]       mant;
  logic [31:0]       mag;
  logic [4:0]        sh;

  assign sign    = op[31];
  assign exp_b   = op[30:23];
  assign frac    = op[22:0];
  // 10-bit signed so that e-127 never wraps
  assign exp_unb = $signed({2'b00, exp_b}) - $signed(10'(F32_BIAS));
  assign mant    = {8'h00, 1'b1, frac};

  always_comb begin
    res = '0;
    sat = 1'b0;
    mag = '0;
    sh  = '0;
    if (exp_b == 8'h00) begin
      res = '0;
    end else if (exp_b == 8'hFF) begin
      sat = 1'b1;
      res = sat_value(sign);
    end else if (exp_unb < 10'sd0) begin
      res = '0;
    end else if (exp_unb >= 10'sd31) begin
      if (op == F32_NEG_2P31) begin
        res = INT_MIN;
      end else begin
        sat = 1'b1;
        res = sat_value(sign);
      end
    end else begin
      if (exp_unb >= 10'sd23) begin
        sh  = exp_unb[4:0] - 5'd23;
        mag = mant << sh;
      end else begin
        sh  = 5'd23 - exp_unb[4:0];
        mag = mant >> sh;
      end
      res = sign ? (~mag + 32'd1) : mag;
    end
  end

endmodule

// File: rtl/f2i_share_arbiter.sv
// Round-robin arbiter sharing one float-to-int converter among NREQ
// requesters; holds each tagged result until the response port accepts it.
//
// state | meaning
// IDLE  | grant round-robin winner combinationally, capture its operand
// CONV  | converter evaluates op_q, result and sat flag are registered
// RESP  | rsp_valid held with stable data until rsp_ready
module f2i_share_arbiter
  import f2i_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_sat,
  output logic [CNTW-1:0]      sat_count
);

  f2i_state_e state_q, state_d;

  logic [31:0]     op_q;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  last_q;
  logic [31:0]     res_q;
  logic            sat_q;
  logic            rsp_valid_q;
  logic [CNTW-1:0] sat_cnt_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_id;
  logic [31:0]     op_sel;
  logic [31:0]     core_res;
  logic            core_sat;
  logic            take;

  // Two passes: indices above last first, then wrap to the ones at/below it.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [IDW-1:0]  last);
    logic [NREQ-1:0] g;
    logic            found;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid[i] && (i > int'(last))) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid[i] && (i <= int'(last))) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  assign grant = rr_pick(req_valid, last_q);

  always_comb begin
    win_id = '0;
    op_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_id = IDW'(i);
        op_sel = req_data[32*i +: 32];
      end
    end
  end

  f2i_convert_core u_core (
    .op  (op_q),
    .res (core_res),
    .sat (core_sat)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    take      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant;
          take      = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      id_q        <= '0;
      last_q      <= IDW'(NREQ - 1);
      res_q       <= '0;
      sat_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        op_q   <= op_sel;
        id_q   <= win_id;
        last_q <= win_id;
      end
      if (state_q == CONV) begin
        res_q       <= core_res;
        sat_q       <= core_sat;
        rsp_valid_q <= 1'b1;
        // counts on the edge that enters RESP with the flag set; sticks at max
        if (core_sat && !(&sat_cnt_q)) sat_cnt_q <= sat_cnt_q + CNTW'(1);
      end
      if ((state_q == RESP) && rsp_ready) rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = res_q;
  assign rsp_id    = id_q;
  assign rsp_sat   = sat_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_f2i_share_arbiter.sv
// Directed bench for f2i_share_arbiter: vector table of conversions plus
// sequences for round robin, backpressure, counter saturation and reset.
module tb_f2i_share_arbiter;
  import f2i_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready, req_ready2;
  logic         rsp_valid, rsp_valid2;
  logic         rsp_ready;
  logic [31:0]  rsp_data, rsp_data2;
  logic [1:0]   rsp_id, rsp_id2;
  logic         rsp_sat, rsp_sat2;
  logic [15:0]  sat_count;
  logic [1:0]   sat_count2;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  f2i_share_arbiter #(.NREQ(4), .CNTW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_sat(rsp_sat), .sat_count(sat_count)
  );

  f2i_share_arbiter #(.NREQ(4), .CNTW(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data2), .rsp_id(rsp_id2), .rsp_sat(rsp_sat2), .sat_count(sat_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic        sat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One isolated transaction from requester idx; entered and left at #1 past posedge in IDLE.
  task automatic do_op(input int idx, input logic [31:0] op,
                       input logic [31:0] exp_res, input logic exp_sat);
    req_valid              = '0;
    req_valid[idx]         = 1'b1;
    req_data[32*idx +: 32] = op;
    rsp_ready              = 1'b1;
    @(negedge clk);
    check("grant", req_ready, 64'(1 << idx));
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("latency_conv", rsp_valid, 0);
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, exp_res);
    check("rsp_id", rsp_id, idx);
    check("rsp_sat", rsp_sat, exp_sat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   prev;
    logic found;
    vecs[0]  = '{32'h4128_0000, 32'd10,          1'b0};
    vecs[1]  = '{32'hC128_0000, 32'hFFFF_FFF6,   1'b0};
    vecs[2]  = '{32'h3F00_0000, 32'd0,           1'b0};
    vecs[3]  = '{32'h0000_0001, 32'd0,           1'b0};
    vecs[4]  = '{32'h4F00_0000, 32'h7FFF_FFFF,   1'b1};
    vecs[5]  = '{32'hCF00_0000, 32'h8000_0000,   1'b0};
    vecs[6]  = '{32'h7FC0_0000, 32'h7FFF_FFFF,   1'b1};
    vecs[7]  = '{32'h3F80_0000, 32'd1,           1'b0};
    vecs[8]  = '{32'hBFC0_0000, 32'hFFFF_FFFF,   1'b0};
    vecs[9]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80,   1'b0};
    vecs[10] = '{32'hFF80_0000, 32'h8000_0000,   1'b1};
    vecs[11] = '{32'hCF00_0001, 32'h8000_0000,   1'b1};
    vecs[12] = '{32'h4B00_0001, 32'h0080_0001,   1'b0};
    vecs[13] = '{32'h8000_0000, 32'd0,           1'b0};

    req_data = '0;
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_sat", rsp_sat, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_req_ready", req_ready, 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) do_op(i % 4, vecs[i].op, vecs[i].res, vecs[i].sat);

    // saturation counter, full width and 2-bit instance
    do_reset();
    for (int k = 0; k < 3; k++) do_op(1, 32'h4F00_0000, INT_MAX, 1'b1);
    check("sat_count_3", sat_count, 3);
    check("sat_count2_3", sat_count2, 3);
    for (int k = 0; k < 2; k++) do_op(2, 32'hCF80_0000, INT_MIN, 1'b1);
    check("sat_count_5", sat_count, 5);
    check("sat_count2_hold", sat_count2, 3);

    // fairness: all four held valid, expect 0,1,2,3,0 every 3 cycles
    do_reset();
    req_data  = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    prev      = 0;
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      for (int t = 0; t < 10 && !found; t++) begin
        @(negedge clk);
        if (req_ready != 4'b0000) found = 1'b1;
      end
      check("rr_wait", found, 1);
      check("rr_grant", req_ready, 64'(1 << (k % 4)));
      if (k > 0) check("rr_spacing", cyc - prev, 3);
      prev = cyc;
      @(negedge clk);
      @(negedge clk);
      check("rr_rsp_id", rsp_id, k % 4);
      check("rr_rsp_data", rsp_data, (k % 4) + 1);
    end
    @(posedge clk);
    #1 req_valid = '0;

    // backpressure: grant 1, then hold RESP with requester 2 waiting
    rsp_ready      = 1'b0;
    req_valid      = 4'b0010;
    req_data[63:32] = 32'h4128_0000;
    @(negedge clk);
    check("bp_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid        = 4'b0100;
    req_data[95:64]  = 32'h4040_0000;
    @(negedge clk);
    check("bp_conv_ready", req_ready, 0);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("bp_hold", {rsp_valid, rsp_id, req_ready, rsp_data},
            {1'b1, 2'd1, 4'b0000, 32'd10});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_released", rsp_valid, 0);
    @(negedge clk);
    check("bp_next_grant", req_ready, 4'b0100);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("bp_second_id", rsp_id, 2);
    check("bp_second_data", rsp_data, 3);
    @(posedge clk);
    #1;

    // reset during CONV: request from 3 dropped, then 0 wins after release
    req_valid        = 4'b1000;
    req_data[127:96] = 32'h4F00_0000;
    @(negedge clk);
    check("mr_grant", req_ready, 4'b1000);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_rsp_id", rsp_id, 0);
    check("mr_rsp_data", rsp_data, 0);
    check("mr_req_ready", req_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mr_idle_rsp", rsp_valid, 0);
    @(posedge clk);
    #1;
    req_valid       = 4'b1001;
    req_data[31:0]  = 32'h3F80_0000;
    @(negedge clk);
    check("mr_prio0", req_ready, 4'b0001);
    @(posedge clk);
    #1 req_valid = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    check("mr_rsp0_id", rsp_id, 0);
    check("mr_rsp0_data", rsp_data, 1);
    @(negedge clk);
    check("mr_regrant3", req_ready, 4'b1000);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("mr_rsp3", {rsp_valid, rsp_id, rsp_sat, rsp_data}, {1'b1, 2'd3, 1'b1, INT_MAX});
    check("mr_sat_count", sat_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
